// File: rtl/concat_stream_pkg.sv
// Shared constants for the trunk/branch concatenation block: default element width,
// branch placement selectors and the occupancy counter width helper.
package concat_stream_pkg;

    localparam int N_DEFAULT = 8;

    localparam bit BRANCH_HIGH = 1'b1;
    localparam bit BRANCH_LOW  = 1'b0;

    // Occupancy must represent 0..depth inclusive, hence one bit above the pointer width.
    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/concat_stream_if.sv
// Generic valid/ready stream with one data word; master drives vld/dat, slave drives rdy.
interface concat_stream_if #(
    parameter int W = 8
) ();
    logic         vld;
    logic         rdy;
    logic [W-1:0] dat;

    modport master (output vld, output dat, input rdy);
    modport slave  (input vld, input dat, output rdy);
endinterface

// File: rtl/concat_stream_sync_fifo.sv
// Show-ahead synchronous FIFO with registered occupancy; push ignored when full, pop when empty.
// Head is valid the cycle after the write edge (no write-to-read bypass); clr flushes pointers and count.
module concat_stream_sync_fifo
    import concat_stream_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clr,
    input  logic                      push,
    input  logic [WIDTH-1:0]          din,
    input  logic                      pop,
    output logic [WIDTH-1:0]          head,
    output logic                      full,
    output logic                      empty,
    output logic [cnt_w(DEPTH)-1:0]   cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = cnt_w(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (cnt == CW'(DEPTH));
    assign empty   = (cnt == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !clr) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/concat_stream.sv
// Pairs each branch word with the oldest queued trunk word and emits the concatenation
// through a registered valid/ready stage (1 cycle from branch accept to dout.vld).
module concat_stream
    import concat_stream_pkg::*;
#(
    parameter int N      = N_DEFAULT,
    parameter int CH_L   = 1,
    parameter int CH_B   = 1,
    parameter int DEPTH  = 16,
    parameter bit B_HIGH = BRANCH_HIGH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    concat_stream_if.slave           layer,
    concat_stream_if.slave           branch,
    concat_stream_if.master          dout,
    output logic [cnt_w(DEPTH)-1:0]  fifo_cnt,
    output logic [15:0]              pair_cnt
);
    localparam int LW = CH_L * N;
    localparam int BW = CH_B * N;
    localparam int OW = LW + BW;

    logic [LW-1:0] head;
    logic          full;
    logic          empty;
    logic          br_rdy;
    logic          pair;
    logic [OW-1:0] pair_dat;
    logic          out_vld;
    logic [OW-1:0] out_dat;

    concat_stream_sync_fifo #(
        .WIDTH (LW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr),
        .push  (layer.vld),
        .din   (layer.dat),
        .pop   (pair),
        .head  (head),
        .full  (full),
        .empty (empty),
        .cnt   (fifo_cnt)
    );

    // A pair may only form when the output register is free or draining this cycle.
    assign br_rdy     = ~empty & (~out_vld | dout.rdy);
    assign branch.rdy = br_rdy;
    assign layer.rdy  = ~full;
    assign pair       = branch.vld & br_rdy & ~clr;

    generate
        if (B_HIGH == BRANCH_HIGH) begin : g_branch_msb
            assign pair_dat = {branch.dat, head};
        end else begin : g_branch_lsb
            assign pair_dat = {head, branch.dat};
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_vld  <= 1'b0;
            out_dat  <= '0;
            pair_cnt <= '0;
        end else if (clr) begin
            out_vld  <= 1'b0;
            pair_cnt <= '0;
        end else begin
            if (out_vld && dout.rdy) pair_cnt <= pair_cnt + 16'd1;
            if (pair) begin
                out_dat <= pair_dat;
                out_vld <= 1'b1;
            end else if (dout.rdy) begin
                out_vld <= 1'b0;
            end
        end
    end

    assign dout.vld = out_vld;
    assign dout.dat = out_dat;

endmodule
